data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-port arbiter and sequencer in front of the byte-addressed data memory. It shares the single memory port between the core's MEM stage (port 0) and the host/debug loader (port 1). It grants one access per cycle round-robin, supports a host lock for multi-access sequences, and range-checks every access against memory depth. Read data is registered and returned with `rvalid`, so both requesters see a fixed one-cycle response.

## Interface
- `DEPTH`, 128: memory size in bytes.
- `AW`, 32: address width.
- `DW`, 32: data width.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `mN_req` in 1 (N=0,1): access request. Held with its fields stable until `mN_gnt`.
- `mN_write_mem` in 2: write size code. 00 none, 01 word, 10 half, 11 byte.
- `mN_read_mem` in 3: read size code. [1:0] as above; [2] selects sign-extension.
- `mN_addr` in AW: byte address.
- `mN_wdata` in DW: write data, LSB-aligned.
- `mN_gnt` out 1: request accepted this cycle (combinational).
- `mN_rvalid` out 1: response valid, one cycle after `gnt`.
- `mN_rdata` out DW: registered read data. 0 for writes and errors.
- `mN_err` out 1: qualifies `rvalid`; the access was suppressed.
- `m1_lock` in 1: host holds ownership while high.
- `mem_write_mem` out 2, `mem_read_mem` out 3, `mem_address` out AW, `mem_write_data` out DW: memory port.
- `mem_out` in DW: combinational read data from memory.

## Operation
- **FSM states:**
  - ARB: round-robin between `m0_req` and `m1_req`. `last` is a 1-bit pointer to the last-granted port; with both requesting, the other port wins.
  - LOCK: only port 1 is granted; `m0_gnt` stays 0.
- **Transitions:**
  - ARB→LOCK when port 1 is granted with `m1_lock`=1.
  - LOCK→ARB in the first cycle `m1_lock`=0; that cycle arbitrates normally.
- **Granted cycle:** the winner's fields drive the `mem_*` ports; the idle memory port is all zeros.
- **Size in bytes:** 4/2/1 from the nonzero code, else 0.
- **Error conditions**, each causing `err` with memory codes forced to 00/000:
  - both `write_mem` and `read_mem[1:0]` nonzero;
  - `addr + size > DEPTH`, computed in AW+1 bits so no wrap.
- **No-op:** both codes zero is granted with `rvalid`, `rdata`=0, `err`=0.
- **Unaligned in-range accesses** are legal and passed through unchanged.
- **Response register:** captures `mem_out` (reads) or 0, plus `err` and the port id. The next cycle it asserts only that port's `rvalid`.
- **Access counters:** per-port 16-bit counters `gnt_cnt0`/`gnt_cnt1` (internal, bench-visible) increment on `gnt` and saturate at 0xFFFF.

## Timing
- **Reset values:** state=ARB, `last`=1 (port 0 wins the first tie), all `gnt`/`rvalid`/`err`=0, `rdata`=0, counters=0, `mem_*`=0.
- **Throughput:** one access per cycle total. Back-to-back grants to the same port are allowed when the other port is idle.
- **Latency:**
  - `gnt` in cycle T when `req` is sampled high and the port wins.
  - A write commits at the clk edge ending T.
  - `rvalid`/`rdata`/`err` are valid in T+1.
- **Write then read:** a write at T followed by a read of the same bytes at T+1 returns the new data. No bypass is needed because memory writes are synchronous.
- **`req` dropped before `gnt`:** permitted; nothing is issued.
- **Reset mid-operation:** a pending `rvalid` in T+1 is cancelled. A write at T whose edge coincides with `rst`=1 still commits, because memory is not reset.
- **`m1_lock` with `m1_req`=0:** in ARB there is no effect; in LOCK the lock persists and port 0 is stalled.

## Structure
- **Shared package `dmem_pkg`:**
  - size-code constants: SZ_NONE=2'b00, SZ_WORD=2'b01, SZ_HALF=2'b10, SZ_BYTE=2'b11, RD_SIGNED bit index 2;
  - function `size_bytes(code)`;
  - state enum {ARB, LOCK}.
- **Sub-module `dmem_req_check`:** combinational. Inputs are the codes and address; outputs are `size` and `err`. Instantiated once per port.

## Test plan
- **Tie:** after reset, `m0` reads word @0 and `m1` reads word @4 in the same cycle. Expect `m0_gnt` at T with `m0_rvalid` at T+1, `rdata`=0x00000143. Then `m1_gnt` at T+1 with `m1_rvalid` at T+2, `rdata`=0x0000007B.
- **Fill-in:** `m1` writes byte 0xAA @40 while `m0` is idle. `m0` then reads signed byte @40 → 0xFFFFFFAA; an unsigned read → 0x000000AA.
- **Range errors:**
  - `m0` word read @126 → `err`=1, `rdata`=0, no memory access (`mem_read_mem`=000).
  - `m0` byte read @127 → valid.
- **Malformed request:** `write_mem`=01 with `read_mem`=001 → `err`=1. A readback of the address shows it unchanged.
- **Lock:** `m1_lock`=1 with three host writes @0,4,8 while `m0_req` is held. `m0_gnt` stays 0 until `m1_lock` falls, then is granted in the first ARB cycle. Expect `gnt_cnt1`=3.
- **Reset:** `rst` asserted in the cycle after a read `gnt` → no `rvalid`. All outputs return to reset values, and the next tie goes to port 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: size codes, byte-size helper
// and the arbitration state encoding.
package dmem_pkg;

   localparam logic [1:0] SZ_NONE   = 2'b00;
   localparam logic [1:0] SZ_WORD   = 2'b01;
   localparam logic [1:0] SZ_HALF   = 2'b10;
   localparam logic [1:0] SZ_BYTE   = 2'b11;
   localparam int         RD_SIGNED = 2;

   typedef enum logic {ARB, LOCK} state_e;

   function automatic logic [2:0] size_bytes(input logic [1:0] code);
      case (code)
         SZ_WORD: size_bytes = 3'd4;
         SZ_HALF: size_bytes = 3'd2;
         SZ_BYTE: size_bytes = 3'd1;
         default: size_bytes = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_req_check.sv
// Per-port request decode: access size in bytes and suppression flag for
// malformed (read+write) or out-of-range accesses.
module dmem_req_check
   import dmem_pkg::*;
#(
   parameter int AW    = 32,
   parameter int DEPTH = 128
) (
   input  logic [1:0]    write_mem,
   input  logic [2:0]    read_mem,
   input  logic [AW-1:0] addr,
   output logic [2:0]    size,
   output logic          err
);

   localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

   logic [1:0] code;
   logic [AW:0] end_addr;

   always_comb begin
      code     = (write_mem != SZ_NONE) ? write_mem : read_mem[1:0];
      size     = size_bytes(code);
      // One extra bit so an address near the top of AW cannot wrap into range.
      end_addr = {1'b0, addr} + {{(AW-2){1'b0}}, size};
      err      = ((write_mem != SZ_NONE) && (read_mem[1:0] != SZ_NONE)) ||
                 (end_addr > LIMIT);
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the data-memory port between the core (port 0)
// and the host loader (port 1), with host lock and a one-cycle response.
module data_mem_arbiter
   import dmem_pkg::*;
#(
   parameter int DEPTH = 128,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic [1:0]    m0_write_mem,
   input  logic [2:0]    m0_read_mem,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   output logic          m0_err,
   input  logic          m1_req,
   input  logic [1:0]    m1_write_mem,
   input  logic [2:0]    m1_read_mem,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic          m1_err,
   input  logic          m1_lock,
   output logic [1:0]    mem_write_mem,
   output logic [2:0]    mem_read_mem,
   output logic [AW-1:0] mem_address,
   output logic [DW-1:0] mem_write_data,
   input  logic [DW-1:0] mem_out
);

   state_e        state_q, state_d;
   logic          last_q, last_d;
   logic          rsp_vld_q, rsp_port_q, rsp_err_q;
   logic [DW-1:0] rdata_q;
   logic [15:0]   gnt_cnt0, gnt_cnt1;

   logic [2:0]    size0, size1;
   logic          err0, err1;
   logic          sel_err, sel_rd;

   dmem_req_check #(.AW(AW), .DEPTH(DEPTH)) u_chk0 (
      .write_mem (m0_write_mem),
      .read_mem  (m0_read_mem),
      .addr      (m0_addr),
      .size      (size0),
      .err       (err0)
   );

   dmem_req_check #(.AW(AW), .DEPTH(DEPTH)) u_chk1 (
      .write_mem (m1_write_mem),
      .read_mem  (m1_read_mem),
      .addr      (m1_addr),
      .size      (size1),
      .err       (err1)
   );

   always_comb begin
      m0_gnt         = 1'b0;
      m1_gnt         = 1'b0;
      last_d         = last_q;
      state_d        = ARB;
      mem_write_mem  = SZ_NONE;
      mem_read_mem   = 3'b000;
      mem_address    = '0;
      mem_write_data = '0;
      sel_err        = 1'b0;
      sel_rd         = 1'b0;

      // LOCK with the lock dropped falls through to a normal arbitration cycle.
      if (state_q == LOCK && m1_lock) begin
         m1_gnt = m1_req;
      end else begin
         m0_gnt = m0_req && (!m1_req || last_q);
         m1_gnt = m1_req && (!m0_req || !last_q);
      end

      if (m0_gnt)      last_d = 1'b0;
      else if (m1_gnt) last_d = 1'b1;

      if ((m1_gnt || state_q == LOCK) && m1_lock) state_d = LOCK;

      if (m0_gnt) begin
         mem_address    = m0_addr;
         mem_write_data = m0_wdata;
         sel_err        = err0;
         sel_rd         = !err0 && (size0 != 3'd0) && (m0_write_mem == SZ_NONE);
         if (!err0) begin
            mem_write_mem = m0_write_mem;
            mem_read_mem  = m0_read_mem;
         end
      end else if (m1_gnt) begin
         mem_address    = m1_addr;
         mem_write_data = m1_wdata;
         sel_err        = err1;
         sel_rd         = !err1 && (size1 != 3'd0) && (m1_write_mem == SZ_NONE);
         if (!err1) begin
            mem_write_mem = m1_write_mem;
            mem_read_mem  = m1_read_mem;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB;
         last_q     <= 1'b1;
         rsp_vld_q  <= 1'b0;
         rsp_port_q <= 1'b0;
         rsp_err_q  <= 1'b0;
         rdata_q    <= '0;
         gnt_cnt0   <= '0;
         gnt_cnt1   <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         rsp_vld_q  <= m0_gnt || m1_gnt;
         rsp_port_q <= m1_gnt;
         rsp_err_q  <= sel_err;
         rdata_q    <= sel_rd ? mem_out : '0;
         if (m0_gnt && gnt_cnt0 != 16'hFFFF) gnt_cnt0 <= gnt_cnt0 + 16'd1;
         if (m1_gnt && gnt_cnt1 != 16'hFFFF) gnt_cnt1 <= gnt_cnt1 + 16'd1;
      end
   end

   always_comb begin
      m0_rvalid = rsp_vld_q && !rsp_port_q;
      m1_rvalid = rsp_vld_q &&  rsp_port_q;
      m0_err    = m0_rvalid && rsp_err_q;
      m1_err    = m1_rvalid && rsp_err_q;
      m0_rdata  = m0_rvalid ? rdata_q : '0;
      m1_rdata  = m1_rvalid ? rdata_q : '0;
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a byte-addressed memory model
// (synchronous write, combinational sign/zero-extending read).
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m1_req, m1_lock;
   logic [1:0]  m0_write_mem, m1_write_mem;
   logic [2:0]  m0_read_mem, m1_read_mem;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic [1:0]  mem_write_mem;
   logic [2:0]  mem_read_mem;
   logic [31:0] mem_address, mem_write_data, mem_out;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [0:127];
   logic [6:0] ma;

   always #5 clk = ~clk;

   data_mem_arbiter #(.DEPTH(128), .AW(32), .DW(32)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_write_mem(m0_write_mem), .m0_read_mem(m0_read_mem),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
      .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_write_mem(m1_write_mem), .m1_read_mem(m1_read_mem),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
      .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .m1_lock(m1_lock),
      .mem_write_mem(mem_write_mem), .mem_read_mem(mem_read_mem),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_out(mem_out)
   );

   always_comb begin
      ma      = mem_address[6:0];
      mem_out = 32'h0;
      case (mem_read_mem[1:0])
         2'b01: mem_out = {mem[ma+7'd3], mem[ma+7'd2], mem[ma+7'd1], mem[ma]};
         2'b10: mem_out = {{16{mem_read_mem[2] & mem[ma+7'd1][7]}}, mem[ma+7'd1], mem[ma]};
         2'b11: mem_out = {{24{mem_read_mem[2] & mem[ma][7]}}, mem[ma]};
         default: mem_out = 32'h0;
      endcase
   end

   always @(posedge clk) begin
      case (mem_write_mem)
         2'b01: begin
            mem[ma]       <= mem_write_data[7:0];
            mem[ma+7'd1]  <= mem_write_data[15:8];
            mem[ma+7'd2]  <= mem_write_data[23:16];
            mem[ma+7'd3]  <= mem_write_data[31:24];
         end
         2'b10: begin
            mem[ma]       <= mem_write_data[7:0];
            mem[ma+7'd1]  <= mem_write_data[15:8];
         end
         2'b11: mem[ma]   <= mem_write_data[7:0];
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic mid;
      @(negedge clk);
   endtask

   task automatic drv0(input logic req, input logic [1:0] wm, input logic [2:0] rm,
                       input logic [31:0] a, input logic [31:0] wd);
      m0_req = req; m0_write_mem = wm; m0_read_mem = rm; m0_addr = a; m0_wdata = wd;
   endtask

   task automatic drv1(input logic req, input logic [1:0] wm, input logic [2:0] rm,
                       input logic [31:0] a, input logic [31:0] wd);
      m1_req = req; m1_write_mem = wm; m1_read_mem = rm; m1_addr = a; m1_wdata = wd;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
      mem[0] = 8'h43; mem[1] = 8'h01;
      mem[4] = 8'h7B;
      mem[8] = 8'h44; mem[9] = 8'h33; mem[10] = 8'h22; mem[11] = 8'h11;
      mem[127] = 8'h5C;

      rst = 1'b1; m1_lock = 1'b0;
      drv0(0, 2'b00, 3'b000, 0, 0);
      drv1(0, 2'b00, 3'b000, 0, 0);
      tick; tick;
      mid;
      chk("rst_m0_gnt", {31'b0, m0_gnt}, 0);
      chk("rst_m1_rvalid", {31'b0, m1_rvalid}, 0);
      chk("rst_m0_rdata", m0_rdata, 0);
      chk("rst_mem_addr", mem_address, 0);
      chk("rst_cnt0", {16'b0, dut.gnt_cnt0}, 0);

      // Tie: port 0 wins first
      tick; rst = 1'b0;
      drv0(1, 2'b00, 3'b001, 0, 0);
      drv1(1, 2'b00, 3'b001, 4, 0);
      mid;
      chk("tie_m0_gnt", {31'b0, m0_gnt}, 1);
      chk("tie_m1_gnt", {31'b0, m1_gnt}, 0);
      tick; drv0(0, 2'b00, 3'b000, 0, 0);
      mid;
      chk("tie_m0_rvalid", {31'b0, m0_rvalid}, 1);
      chk("tie_m0_rdata", m0_rdata, 32'h0000_0143);
      chk("tie_m1_gnt2", {31'b0, m1_gnt}, 1);
      tick; drv1(0, 2'b00, 3'b000, 0, 0);
      mid;
      chk("tie_m1_rvalid", {31'b0, m1_rvalid}, 1);
      chk("tie_m1_rdata", m1_rdata, 32'h0000_007B);
      chk("tie_m0_rvalid_off", {31'b0, m0_rvalid}, 0);

      // Fill-in: host byte write then core signed/unsigned reads
      tick; drv1(1, 2'b11, 3'b000, 40, 32'h0000_00AA);
      mid;
      chk("fill_m1_gnt", {31'b0, m1_gnt}, 1);
      tick; drv1(0, 2'b00, 3'b000, 0, 0);
      drv0(1, 2'b00, 3'b111, 40, 0);
      mid;
      chk("fill_m0_gnt", {31'b0, m0_gnt}, 1);
      chk("fill_wr_rvalid", {31'b0, m1_rvalid}, 1);
      chk("fill_wr_rdata", m1_rdata, 0);
      chk("fill_wr_err", {31'b0, m1_err}, 0);
      tick; drv0(1, 2'b00, 3'b011, 40, 0);
      mid;
      chk("fill_b2b_gnt", {31'b0, m0_gnt}, 1);
      chk("fill_signed", m0_rdata, 32'hFFFF_FFAA);
      tick; drv0(0, 2'b00, 3'b000, 0, 0);
      mid;
      chk("fill_unsigned", m0_rdata, 32'h0000_00AA);

      // Range: word @126 overruns, byte @127 fits
      tick; drv0(1, 2'b00, 3'b001, 126, 0);
      mid;
      chk("rng_gnt", {31'b0, m0_gnt}, 1);
      chk("rng_mem_rd", {29'b0, mem_read_mem}, 0);
      tick; drv0(1, 2'b00, 3'b011, 127, 0);
      mid;
      chk("rng_err", {31'b0, m0_err}, 1);
      chk("rng_err_rdata", m0_rdata, 0);
      chk("rng_last_mem_rd", {29'b0, mem_read_mem}, 32'd3);
      tick; drv0(0, 2'b00, 3'b000, 0, 0);
      mid;
      chk("rng_last_err", {31'b0, m0_err}, 0);
      chk("rng_last_rdata", m0_rdata, 32'h0000_005C);

      // Malformed: write+read together is suppressed
      tick; drv0(1, 2'b01, 3'b001, 8, 32'hDEAD_BEEF);
      mid;
      chk("bad_mem_wr", {30'b0, mem_write_mem}, 0);
      tick; drv0(1, 2'b00, 3'b001, 8, 0);
      mid;
      chk("bad_err", {31'b0, m0_err}, 1);
      tick; drv0(0, 2'b00, 3'b000, 0, 0);
      mid;
      chk("bad_readback", m0_rdata, 32'h1122_3344);

      // Lock: counters restart from reset
      tick; rst = 1'b1;
      tick; rst = 1'b0;
      m1_lock = 1'b1;
      drv1(1, 2'b01, 3'b000, 0, 32'h1000_0001);
      mid;
      chk("lk_first_gnt", {31'b0, m1_gnt}, 1);
      tick; drv0(1, 2'b00, 3'b001, 0, 0);
      drv1(1, 2'b01, 3'b000, 4, 32'h2000_0002);
      mid;
      chk("lk_m1_gnt2", {31'b0, m1_gnt}, 1);
      chk("lk_m0_stall2", {31'b0, m0_gnt}, 0);
      tick; drv1(1, 2'b01, 3'b000, 8, 32'h3000_0003);
      mid;
      chk("lk_m0_stall3", {31'b0, m0_gnt}, 0);
      tick; drv1(0, 2'b00, 3'b000, 0, 0);
      mid;
      chk("lk_persist", {31'b0, m0_gnt}, 0);
      tick; m1_lock = 1'b0;
      mid;
      chk("lk_release_gnt", {31'b0, m0_gnt}, 1);
      tick; drv0(0, 2'b00, 3'b000, 0, 0);
      mid;
      chk("lk_readback", m0_rdata, 32'h1000_0001);
      chk("lk_cnt1", {16'b0, dut.gnt_cnt1}, 3);
      chk("lk_cnt0", {16'b0, dut.gnt_cnt0}, 1);

      // Reset mid-operation
      tick; rst = 1'b1; drv0(1, 2'b00, 3'b001, 4, 0);
      mid;
      chk("mr_gnt", {31'b0, m0_gnt}, 1);
      tick; drv0(0, 2'b00, 3'b000, 0, 0);
      drv1(1, 2'b01, 3'b000, 16, 32'hCAFE_F00D);
      mid;
      chk("mr_no_rvalid", {31'b0, m0_rvalid}, 0);
      chk("mr_wr_gnt", {31'b0, m1_gnt}, 1);
      tick; rst = 1'b0;
      drv0(1, 2'b00, 3'b001, 16, 0);
      drv1(1, 2'b00, 3'b001, 0, 0);
      mid;
      chk("mr_no_rvalid1", {31'b0, m1_rvalid}, 0);
      chk("mr_tie_m0", {31'b0, m0_gnt}, 1);
      chk("mr_tie_m1", {31'b0, m1_gnt}, 0);
      chk("mr_cnt1", {16'b0, dut.gnt_cnt1}, 0);
      tick; drv0(0, 2'b00, 3'b000, 0, 0);
      mid;
      chk("mr_wr_committed", m0_rdata, 32'hCAFE_F00D);
      chk("mr_m1_gnt", {31'b0, m1_gnt}, 1);
      tick; drv1(0, 2'b00, 3'b000, 0, 0);
      mid;
      chk("mr_m1_rdata", m1_rdata, 32'h1000_0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
